serial_subtractor_nb: RTL and testbench
=======================================

Name: serial_subtractor_nb

Overview:
- Bit-serial N-bit subtractor with borrow: computes diff = a - b - bin, processing one bit per clock, LSB first.
- Sequential counterpart to the combinational N-bit ripple full adder: it trades N cycles of latency for a single 1-bit full-subtractor cell.
- Driven by a start/busy/done handshake from a datapath controller.
- Results are registered and held until the next operation completes.

Parameters:
- N, 16, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  N  minuend; captured on the accepted start edge
- b  input  N  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when a result is valid
- diff  output  N  result a - b - bin, modulo 2^N
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset: when rst is high at an edge, the next state is:
  - state = IDLE
  - busy = 0, done = 0, diff = 0, bout = 0, ovf = 0
  - internal shift registers, bit counter and borrow flop = 0
- Reset overrides every other input, including mid-operation. An aborted operation produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1 at edge E0: latch a, b and bin into internal registers (borrow flop = bin, counter = 0), then go to SHIFT with busy = 1.
  - Otherwise stay in IDLE.
- SHIFT, at each edge E1..EN (bit i = counter, using the LSB of the shifted a/b registers):
  - d_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d_i into the result register from the MSB side; shift the a/b registers right by 1; increment the counter.
- On edge EN (counter = N-1):
  - Load diff from the completed result register; bout = final br'.
  - ovf = (a[N-1] ^ b[N-1]) & (a[N-1] ^ diff[N-1]), using the latched operand MSBs.
  - Go to DONE: busy = 0, done = 1.
- DONE: at the next edge, return to IDLE with done = 0.
- Latency: done is high in the cycle following edge EN, exactly N clock edges after the start edge. The repeat interval is N+2 cycles.
- start is ignored in SHIFT and DONE: no re-latch, no queueing. A start held high continuously is accepted again on the first edge in IDLE.
- a, b and bin may change freely after the start edge without affecting the result in progress.
- diff, bout and ovf change only on the EN edge or on reset. They hold their value during IDLE and during a subsequent SHIFT.
- Counter width is $clog2(N). There is no arithmetic beyond the 1-bit cell, so all results wrap modulo 2^N.
- bin = 1 with a = b produces diff = all ones and bout = 1.

Test Plan:
- N=16, a=0x0005, b=0x0003, bin=0, start pulse at E0 -> busy high for 16 cycles; done high only in the cycle after E16; diff=0x0002, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF (i.e. -1) -> diff=0x8000, bout=1, ovf=1.
- Start a=0x0010, b=0x0001; at edge E3 pulse start with a=0x1234, b=0x0034 and change the a/b inputs -> ignored; diff=0x000F at done; exactly one done pulse.
- rst high at edge E5 of an operation -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse for 20 cycles. A new start with a=0x0009, b=0x0004 then yields diff=0x0005.
- N=4 exhaustive run: all a, b in 0..15, bin in {0,1}, back-to-back starts -> each result matches (a - b - bin) mod 16, bout = (a < b + bin), and ovf matches the signed reference model.

Source files
------------

// File: rtl/serial_subtractor_nb.sv
// serial_subtractor_nb: bit-serial N-bit a - b - bin, one full-subtractor cell, LSB first
module serial_subtractor_nb #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [N-1:0] ra, rb, res;
    logic [CW-1:0] cnt;
    logic br, am, bm, d, br_nx, last;
    always_comb begin
        d = ra[0] ^ rb[0] ^ br;
        br_nx = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        last = cnt == CW'(N - 1);
        state_nx = (state == IDLE) ? (start ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
        busy = state == SHIFT;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra <= '0;
            rb <= '0;
            res <= '0;
            cnt <= '0;
            br <= 1'b0;
            am <= 1'b0;
            bm <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                ra <= a;
                rb <= b;
                br <= bin;
                cnt <= '0;
                am <= a[N-1];
                bm <= b[N-1];
            end else if (state == SHIFT) begin
                ra <= ra >> 1;
                rb <= rb >> 1;
                res <= {d, res[N-1:1]};
                br <= br_nx;
                cnt <= cnt + CW'(1);
                // the final cell output d is the result MSB, so overflow needs no extra flop
                if (last) begin
                    diff <= {d, res[N-1:1]};
                    bout <= br_nx;
                    ovf <= (am ^ bm) & (am ^ d);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor_nb.sv
// tb_serial_subtractor_nb: vector table and corner sequences on N=16, exhaustive run on N=4
module tb_serial_subtractor_nb;
    typedef struct {logic [15:0] d; logic bo; logic ov;} exp_t;
    typedef struct {logic [15:0] a; logic [15:0] b; logic bin; logic [15:0] d; logic bo; logic ov;} vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16 = 1'b1, start16 = 1'b0, bin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic busy16, done16, bout16, ovf16;
    logic rst4 = 1'b1, start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic busy4, done4, bout4, ovf4;

    int nvec = 0, nfail = 0, ndone16 = 0, n0;
    exp_t q16[$], q4[$];
    exp_t e16, e4;
    vec_t tbl[6];

    serial_subtractor_nb #(.N(16)) u16 (
        .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );
    serial_subtractor_nb #(.N(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model4(input int a, input int b, input int bin);
        exp_t e;
        int sa = (a > 7) ? a - 16 : a;
        int sb = (b > 7) ? b - 16 : b;
        int r = sa - sb - bin;
        e.d = 16'((a - b - bin) & 15);
        e.bo = a < b + bin;
        e.ov = (r < -8) || (r > 7);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            ndone16++;
            if (q16.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL done16 unexpected: got diff 0x%0h, expected no done", diff16);
            end else begin
                e16 = q16.pop_front();
                check("diff16", int'(diff16), int'(e16.d));
                check("bout16", int'(bout16), int'(e16.bo));
                check("ovf16", int'(ovf16), int'(e16.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL done4 unexpected: got diff 0x%0h, expected no done", diff4);
            end else begin
                e4 = q4.pop_front();
                check("diff4", int'(diff4), int'(e4.d));
                check("bout4", int'(bout4), int'(e4.bo));
                check("ovf4", int'(ovf4), int'(e4.ov));
            end
        end
    end

    // call at a negedge with u16 idle; returns at the negedge after the DONE->IDLE edge
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] d, input logic bo, input logic ov);
        a16 = a;
        b16 = b;
        bin16 = bin;
        start16 = 1'b1;
        q16.push_back(exp_t'{d, bo, ov});
        @(negedge clk);
        start16 = 1'b0;
        check("busy after E0", int'(busy16), 1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check("busy mid", int'(busy16), 1);
            check("done mid", int'(done16), 0);
        end
        @(negedge clk);
        check("done after EN", int'(done16), 1);
        check("busy after EN", int'(busy16), 0);
        @(negedge clk);
        check("done cleared", int'(done16), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        repeat (2) @(negedge clk);
        rst16 = 1'b0;
        rst4 = 1'b0;
        check("reset busy16", int'(busy16), 0);
        check("reset done16", int'(done16), 0);
        check("reset diff16", int'(diff16), 0);
        check("reset bout16", int'(bout16), 0);
        check("reset ovf16", int'(ovf16), 0);
        check("reset busy4", int'(busy4), 0);
        check("reset diff4", int'(diff4), 0);
        for (int i = 0; i < 6; i++)
            op16(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].ov);

        // abort mid-operation: no done, outputs cleared
        n0 = ndone16;
        a16 = 16'h00FF;
        b16 = 16'h0001;
        bin16 = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        check("diff held in SHIFT", int'(diff16), 16'h8000);
        check("bout held in SHIFT", int'(bout16), 1);
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        check("abort busy", int'(busy16), 0);
        check("abort done", int'(done16), 0);
        check("abort diff", int'(diff16), 0);
        check("abort bout", int'(bout16), 0);
        check("abort ovf", int'(ovf16), 0);
        repeat (20) @(negedge clk);
        check("no done after abort", ndone16 - n0, 0);
        op16(16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);

        // start during SHIFT is ignored and inputs may change freely
        n0 = ndone16;
        a16 = 16'h0010;
        b16 = 16'h0001;
        bin16 = 1'b0;
        start16 = 1'b1;
        q16.push_back(exp_t'{16'h000F, 1'b0, 1'b0});
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        a16 = 16'h1234;
        b16 = 16'h0034;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'hFFFF;
        b16 = 16'h5555;
        bin16 = 1'b1;
        repeat (16) @(negedge clk);
        check("single done pulse", ndone16 - n0, 1);
        check("idle after ignored start", int'(busy16), 0);
        check("diff held in IDLE", int'(diff16), 16'h000F);

        // N=4 exhaustive, start held high so each op is accepted on the first IDLE edge
        start4 = 1'b1;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia);
                    b4 = 4'(ib);
                    bin4 = 1'(ic);
                    q4.push_back(model4(ia, ib, ic));
                    repeat (6) @(negedge clk);
                end
        start4 = 1'b0;
        repeat (10) @(negedge clk);
        check("q4 drained", q4.size(), 0);
        check("q16 drained", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
